case_stream_ctrl: RTL and testbench
===================================

CASE_STREAM_CTRL -- requirements
Module: case_stream_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous active-high reset.
REQ-003 in_valid  in  1  upstream byte present.
REQ-004 in_ready  out  1  block accepts byte; transfer when in_valid && in_ready.
REQ-005 in_char  in  8  input byte, bit 7 = MSB.
REQ-006 mode  in  2  00 pass, 01 to-upper, 10 to-lower, 11 toggle-case.
REQ-007 out_valid  out  1  out_char holds a converted byte.
REQ-008 out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
REQ-009 out_char  out  8  converted byte.
REQ-010 out_last  out  1  out_char is a line terminator.
REQ-011 busy  out  1  high when state != IDLE, FIFO non-empty, or out_valid.
REQ-012 conv_count  out  16  count of bytes modified in current/last line.
REQ-013 line_done  out  1  one-cycle pulse after the terminator transfers out.

Function
REQ-014 Input bytes SHALL enter a 4-entry FIFO; in_ready = !fifo_full && !rst; no same-cycle push when full.
REQ-015 A single output register SHALL load the FIFO head, converted, whenever it is empty or its byte transfers this cycle; no FIFO bypass.
REQ-016 Minimum latency SHALL be: byte accepted at edge N is on out_char with out_valid=1 in the cycle after edge N+1.
REQ-017 Throughput SHALL be one byte/cycle sustained with out_ready=1; byte order SHALL be preserved.
REQ-018 out_char, out_valid and out_last SHALL hold stable while out_valid && !out_ready.
REQ-019 Upper mode SHALL map 0x61-0x7A to byte-0x20; lower mode SHALL map 0x41-0x5A to byte+0x20; toggle SHALL apply both; pass SHALL change nothing.
REQ-020 Bytes with bit 7 set, and all bytes outside those ranges (including 0x40, 0x5B, 0x60, 0x7B), SHALL pass unchanged in every mode.
REQ-021 Terminators are 0x0A and 0x00; they SHALL pass unchanged with out_last=1.
REQ-022 FSM states: IDLE, ACTIVE, DONE.
REQ-023 IDLE->ACTIVE when a byte loads into the output register; on that load mode SHALL be latched and conv_count cleared before counting that byte.
REQ-024 In ACTIVE, the latched mode SHALL be used; changes on mode SHALL be ignored until the next line.
REQ-025 ACTIVE->DONE when a byte with out_last=1 transfers out; DONE->IDLE unconditionally after one cycle; line_done=1 only in DONE.
REQ-026 A terminator loaded in IDLE SHALL form a one-byte line (IDLE->ACTIVE->DONE).
REQ-027 conv_count SHALL increment when a loaded byte differs after conversion, saturate at 0xFFFF, and hold its value in DONE/IDLE until the next line start.
REQ-028 Bytes of the next line MAY be accepted into the FIFO during ACTIVE/DONE; the output register SHALL not load while in DONE.

Reset
REQ-029 While rst=1 at an edge: FIFO emptied, state=IDLE, out_valid=0, out_last=0, out_char=0x00, conv_count=0, line_done=0, latched mode=00.
REQ-030 in_ready SHALL be 0 while rst=1; busy SHALL be 0 in the cycle after reset.
REQ-031 Reset mid-line SHALL discard all buffered bytes; none SHALL appear afterwards.

Verification
REQ-032 mode=01, out_ready=1, send 0x61,0x5A,0x7B,0x0A -> out 0x41,0x5A,0x7B,0x0A; out_last only on 0x0A; conv_count=1; line_done one cycle.
REQ-033 Single 0x6D accepted at edge N, mode=01 -> out_valid first high after edge N+1 with out_char=0x4D.
REQ-034 out_ready=0, in_valid=1 with 6 bytes -> exactly 5 accepted then in_ready=0; on release, outputs in order.
REQ-035 mode=11, send 0x61,0x42,0x31,0xE9,0x00, switch mode to 00 after first byte -> 0x41,0x62,0x31,0xE9,0x00; conv_count=2.
REQ-036 Boundary sweep 0x40,0x5B,0x60,0x7B,0x80,0xFF in each mode -> all unchanged; conv_count=0.
REQ-037 3 bytes buffered, rst pulsed one cycle -> out_valid=0, in_ready=0 during rst, conv_count=0, no stale bytes emitted afterwards.

Source files
------------

// File: rtl/case_stream_if.sv
// Byte-stream handshake bundle for the case converter: upstream bytes in,
// converted bytes out, plus line status.
interface case_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        out_last;
    logic        busy;
    logic [15:0] conv_count;
    logic        line_done;

    modport slave (
        input  in_valid, in_char, mode, out_ready,
        output in_ready, out_valid, out_char, out_last, busy, conv_count, line_done
    );

    modport master (
        output in_valid, in_char, mode, out_ready,
        input  in_ready, out_valid, out_char, out_last, busy, conv_count, line_done
    );
endinterface

// File: rtl/case_stream_ctrl.sv
// Line-oriented ASCII case converter: 4-deep input FIFO feeding one output
// register, with a per-line mode latch and count of modified bytes.
module case_stream_ctrl (
    input  logic         clk,
    input  logic         rst,
    case_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  out_char_q, out_char_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        line_done_q, line_done_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] conv_count_q, conv_count_d;

    logic        fifo_empty, fifo_full, push, load, out_xfer;
    logic        head_term, head_changed;
    logic [7:0]  head, head_conv;
    logic [1:0]  eff_mode;

    function automatic logic [7:0] convert(input logic [7:0] c, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        is_lower = (c >= 8'h61) && (c <= 8'h7A);
        is_upper = (c >= 8'h41) && (c <= 8'h5A);
        convert  = c;
        if (m[0] && is_lower) begin
            convert = c - 8'h20;
        end else if (m[1] && is_upper) begin
            convert = c + 8'h20;
        end
    endfunction

    // A terminator never shares an edge with the next line's first load, so
    // every line start is seen in IDLE where the mode gets latched.
    always_comb begin
        fifo_empty   = (count_q == 3'd0);
        fifo_full    = (count_q == 3'd4);
        push         = bus.in_valid && !fifo_full && !rst;
        out_xfer     = out_valid_q && bus.out_ready;
        load         = !fifo_empty && (state_q != DONE) &&
                       (!out_valid_q || (out_xfer && !out_last_q));
        head         = fifo_q[rd_ptr_q];
        eff_mode     = (state_q == IDLE) ? bus.mode : mode_q;
        head_conv    = convert(head, eff_mode);
        head_term    = (head == 8'h00) || (head == 8'h0A);
        head_changed = (head_conv != head);

        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {2'b00, push} - {2'b00, load};
        out_char_d   = out_char_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        state_d      = state_q;
        mode_d       = mode_q;
        conv_count_d = conv_count_q;
        line_done_d  = 1'b0;

        if (push) begin
            fifo_d[wr_ptr_q] = bus.in_char;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end

        if (load) begin
            rd_ptr_d    = rd_ptr_q + 2'd1;
            out_char_d  = head_conv;
            out_valid_d = 1'b1;
            out_last_d  = head_term;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d      = ACTIVE;
                    mode_d       = bus.mode;
                    conv_count_d = {15'd0, head_changed};
                end
            end
            ACTIVE: begin
                if (out_xfer && out_last_q) begin
                    state_d     = DONE;
                    line_done_d = 1'b1;
                end else if (load && head_changed && (conv_count_q != 16'hFFFF)) begin
                    conv_count_d = conv_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            out_char_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            line_done_q  <= 1'b0;
            mode_q       <= 2'b00;
            conv_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_char_q   <= out_char_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            line_done_q  <= line_done_d;
            mode_q       <= mode_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign bus.in_ready   = !fifo_full && !rst;
    assign bus.out_char   = out_char_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.line_done  = line_done_q;
    assign bus.conv_count = conv_count_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty || out_valid_q;
endmodule

// File: tb/tb_case_stream_ctrl.sv
// Self-checking bench for case_stream_ctrl: directed scenarios plus random
// lines compared against a per-line reference of the case-mapping rules.
module tb_case_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    case_stream_if bus ();

    case_stream_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_asserts = 0;
    int         n_fails   = 0;
    logic [8:0] got [$];
    int         line_done_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val  = 9'd0;
    logic       ld_prev    = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: ASCII letter ranges and the four mode rules.
    function automatic logic [7:0] ref_conv(input logic [7:0] c, input logic [1:0] m);
        logic lower_letter;
        logic upper_letter;
        lower_letter = (c >= 8'h61) && (c <= 8'h7A);
        upper_letter = (c >= 8'h41) && (c <= 8'h5A);
        case (m)
            2'b01:   return lower_letter ? c - 8'd32 : c;
            2'b10:   return upper_letter ? c + 8'd32 : c;
            2'b11:   return lower_letter ? c - 8'd32 : (upper_letter ? c + 8'd32 : c);
            default: return c;
        endcase
    endfunction

    // Output monitor: records transfers, checks stall stability and pulse width.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            ld_prev    = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", bus.out_valid, 1);
                checkOutput("hold_data", {bus.out_last, bus.out_char}, stall_val);
            end
            if (bus.line_done) begin
                line_done_cnt++;
                checkOutput("line_done_pulse", ld_prev, 0);
            end
            ld_prev = bus.line_done;
            if (bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_char});
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_val  = {bus.out_last, bus.out_char};
        end
    end

    task automatic startLine();
        got.delete();
        line_done_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] bytes [$], input int start, input bit rand_ready,
                                 input bit gaps, output int cycles);
        int idx;
        idx    = start;
        cycles = 0;
        while ((idx < bytes.size() || got.size() < bytes.size()) && cycles < 300) begin
            if (idx < bytes.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_char  = bytes[idx];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_char  = 8'($urandom);
            end
            bus.out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            step();
            cycles++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (cycles >= 300) checkOutput("timeout", cycles, 0);
        repeat (3) step();
    endtask

    task automatic checkLine(input string tag, input logic [7:0] bytes [$], input logic [1:0] m);
        logic [8:0] e;
        logic [7:0] c;
        int         changes;
        changes = 0;
        checkOutput({tag, "_len"}, got.size(), bytes.size());
        for (int i = 0; i < bytes.size(); i++) begin
            c = ref_conv(bytes[i], m);
            if (c != bytes[i]) changes++;
            e = {(bytes[i] == 8'h0A) || (bytes[i] == 8'h00), c};
            if (i < got.size()) checkOutput($sformatf("%s_byte%0d", tag, i), got[i], e);
        end
        checkOutput({tag, "_conv"}, bus.conv_count, changes);
        checkOutput({tag, "_line_done"}, line_done_cnt, 1);
        checkOutput({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] b;
        logic [1:0] m;
        int         cyc;
        int         idx;
        int         len;
        bit         seen;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.mode     = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_last", bus.out_last, 0);
        checkOutput("rst_out_char", bus.out_char, 8'h00);
        checkOutput("rst_conv_count", bus.conv_count, 0);
        checkOutput("rst_line_done", bus.line_done, 0);
        checkOutput("post_rst_in_ready", bus.in_ready, 1);
        step();

        // Basic upper-case line with back-to-back bytes and free downstream.
        startLine();
        bus.mode = 2'b01;
        q = {8'h61, 8'h5A, 8'h7B, 8'h0A};
        applyStimulus(q, 0, 1'b0, 1'b0, cyc);
        checkOutput("upper_throughput", cyc, q.size() + 2);
        checkLine("upper", q, 2'b01);

        // First-byte latency.
        startLine();
        bus.mode      = 2'b01;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_char   = 8'h6D;
        @(negedge clk);
        checkOutput("lat_accept", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_early", bus.out_valid, 0);
        step();
        @(negedge clk);
        checkOutput("lat_valid", bus.out_valid, 1);
        checkOutput("lat_char", bus.out_char, 8'h4D);
        step();
        q = {8'h6D, 8'h0A};
        applyStimulus(q, 1, 1'b0, 1'b0, cyc);
        checkLine("lat", q, 2'b01);

        // Backpressure: FIFO plus output register absorb five bytes.
        startLine();
        bus.mode      = 2'b01;
        bus.out_ready = 1'b0;
        q   = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h0A};
        idx = 0;
        repeat (10) begin
            bus.in_valid = 1'b1;
            bus.in_char  = q[idx];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            step();
        end
        checkOutput("bp_accepted", idx, 5);
        @(negedge clk);
        checkOutput("bp_in_ready", bus.in_ready, 0);
        checkOutput("bp_no_output", got.size(), 0);
        step();
        applyStimulus(q, idx, 1'b0, 1'b0, cyc);
        checkLine("bp", q, 2'b01);

        // Toggle mode latched for the whole line despite a mid-line mode change.
        startLine();
        bus.mode      = 2'b11;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_char   = 8'h61;
        @(negedge clk);
        checkOutput("toggle_accept", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
            step();
        end
        checkOutput("toggle_first_out", seen, 1);
        bus.mode = 2'b00;
        q = {8'h61, 8'h42, 8'h31, 8'hE9, 8'h00};
        applyStimulus(q, 1, 1'b1, 1'b1, cyc);
        checkLine("toggle", q, 2'b11);

        // Range boundaries and high-bit bytes stay untouched in every mode.
        for (int mi = 0; mi < 4; mi++) begin
            startLine();
            bus.mode = 2'(mi);
            q = {8'h40, 8'h5B, 8'h60, 8'h7B, 8'h80, 8'hFF, 8'h0A};
            applyStimulus(q, 0, 1'b1, 1'b1, cyc);
            checkLine($sformatf("sweep_m%0d", mi), q, 2'(mi));
        end

        // Reset in the middle of a line discards everything buffered.
        startLine();
        bus.mode      = 2'b01;
        bus.out_ready = 1'b0;
        q   = {8'h61, 8'h62, 8'h63};
        idx = 0;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_char  = q[idx];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            step();
        end
        bus.in_valid = 1'b0;
        checkOutput("mid_rst_buffered", idx, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", bus.out_valid, 0);
        checkOutput("mid_rst_conv", bus.conv_count, 0);
        checkOutput("mid_rst_busy", bus.busy, 0);
        step();
        bus.out_ready = 1'b1;
        repeat (8) step();
        checkOutput("mid_rst_stale", got.size(), 0);
        startLine();
        q = {8'h7A, 8'h0A};
        applyStimulus(q, 0, 1'b0, 1'b0, cyc);
        checkLine("post_rst", q, 2'b01);

        // Random lines, random mode, random gaps and backpressure.
        for (int ln = 0; ln < 10; ln++) begin
            startLine();
            q.delete();
            len = $urandom_range(0, 11);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       b = 8'(8'h41 + $urandom_range(0, 25));
                    1:       b = 8'(8'h61 + $urandom_range(0, 25));
                    2:       b = 8'($urandom_range(1, 255));
                    default: b = 8'($urandom_range(8'h3F, 8'h7C));
                endcase
                if (b == 8'h0A) b = 8'h20;
                q.push_back(b);
            end
            q.push_back(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h00);
            m = 2'($urandom_range(0, 3));
            bus.mode = m;
            applyStimulus(q, 0, 1'b1, 1'b1, cyc);
            checkLine($sformatf("rand%0d", ln), q, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
